// File: rtl/lb_baud_gen.sv
// lb_baud_gen: fractional NCO baud generator producing oversample, bit and mid-bit ticks
module lb_baud_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       baud_sel,
  input  logic             use_custom,
  input  logic [ACC_W-1:0] custom_inc,
  input  logic             sync_clr,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [ACC_W-1:0] inc_out
);
  localparam int CW = $clog2(OVERSAMPLE);
  function automatic logic [ACC_W-1:0] inc_of(input int i);
    logic [63:0] r, v;
    case (i)
      0:       r = 64'd300;
      1:       r = 64'd1200;
      2:       r = 64'd2400;
      3:       r = 64'd4800;
      5:       r = 64'd19200;
      6:       r = 64'd38400;
      7:       r = 64'd57600;
      8:       r = 64'd115200;
      9:       r = 64'd230400;
      10:      r = 64'd460800;
      11:      r = 64'd921600;
      default: r = 64'd9600;
    endcase
    v = (r * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
    return v >= (64'd1 << ACC_W) ? {ACC_W{1'b1}} : v[ACC_W-1:0];
  endfunction
  localparam logic [ACC_W-1:0] INC_DEF = inc_of(4);
  logic [ACC_W-1:0] tab [16];
  logic [ACC_W-1:0] inc_q, inc_nxt, acc;
  logic [ACC_W:0]   sum;
  logic [CW-1:0]    os_cnt;
  for (genvar i = 0; i < 16; i++) begin : g_tab
    localparam logic [ACC_W-1:0] V = inc_of(i);
    assign tab[i] = V;
  end
  assign inc_nxt = use_custom ? custom_inc : tab[baud_sel];
  assign sum = {1'b0, acc} + {1'b0, inc_q};
  assign inc_out = inc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= INC_DEF;
      acc <= '0;
      os_cnt <= '0;
      os_tick <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      if (inc_nxt != inc_q) begin
        inc_q <= inc_nxt;
        acc <= '0;
        os_cnt <= '0;
      end else if (sync_clr) begin
        acc <= '0;
        os_cnt <= '0;
      end else if (enable) begin
        acc <= sum[ACC_W-1:0];
        os_tick <= sum[ACC_W];
        bit_tick <= sum[ACC_W] && os_cnt == CW'(OVERSAMPLE - 1);
        mid_tick <= sum[ACC_W] && os_cnt == CW'(OVERSAMPLE / 2 - 1);
        if (sum[ACC_W]) os_cnt <= os_cnt == CW'(OVERSAMPLE - 1) ? '0 : os_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/lb_baud_gen.md
# lb_baud_gen

Parametrised fractional baud-rate generator for the UART links. It produces an oversample tick, a bit tick and a mid-bit sample tick from one system clock. A phase accumulator (NCO) holds the long-run rate error near zero at any CLK_HZ, where a rounded integer divider does not. It sits between the peripheral's baud-select register and the UART TX/RX engines, and adds a software-programmed custom rate and a phase restart for RX start-bit alignment.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- OVERSAMPLE, 16: os_ticks per bit. Must be an even value from 4 to 64.
- ACC_W, 24: phase accumulator width, from 16 to 32.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when high the accumulator advances; when low all state holds.
- baud_sel  in  4  table index, used when use_custom=0.
- use_custom  in  1  when 1, custom_inc replaces the table entry.
- custom_inc  in  ACC_W  software-provided phase increment.
- sync_clr  in  1  restarts the bit phase (clears acc and os_cnt).
- os_tick  out  1  one-cycle pulse at the oversample rate.
- bit_tick  out  1  one-cycle pulse once every OVERSAMPLE os_ticks.
- mid_tick  out  1  one-cycle pulse at the centre of each bit.
- inc_out  out  ACC_W  the increment currently in use (for readback).

## Operation
- Table entries are constants computed at elaboration: INC(b) = floor((b*OVERSAMPLE*2^ACC_W + CLK_HZ/2) / CLK_HZ), using 64-bit arithmetic. If the result is ≥ 2^ACC_W it clamps to 2^ACC_W−1.
- baud_sel index to rate: 0=300, 1=1200, 2=2400, 3=4800, 4=9600, 5=19200, 6=38400, 7=57600, 8=115200, 9=230400, 10=460800, 11=921600. Indices 12–15 select 9600.
- inc_nxt = use_custom ? custom_inc : INC(baud_sel).
- inc_q is a register. When inc_nxt ≠ inc_q, on that edge:
  - inc_nxt loads into inc_q,
  - acc and os_cnt clear to 0,
  - no tick is issued.
  This happens regardless of enable.
- Otherwise, with enable=1, each edge computes {carry, acc} = acc + inc_q, an ACC_W+1-bit sum where the carry is the top bit. A carry registers os_tick=1 for one cycle.
- os_cnt counts 0..OVERSAMPLE−1 and advances on each carry.
  - A carry with os_cnt = OVERSAMPLE−1 wraps os_cnt to 0 and sets bit_tick=1.
  - A carry with os_cnt = OVERSAMPLE/2−1 sets mid_tick=1.
  - bit_tick and mid_tick are always coincident with os_tick.
- enable=0: acc and os_cnt hold, and all ticks are 0.
- sync_clr=1: acc and os_cnt clear to 0 and no tick is issued, even when a carry would occur that edge. It takes priority over enable.
- inc_q=0 (custom value 0): no ticks ever.
- Priority order: rst > increment change > sync_clr > enable/advance.

## Timing
- Reset values: acc=0, os_cnt=0, os_tick=bit_tick=mid_tick=0, inc_q=INC(9600) so inc_out equals that value.
- All outputs are registered; there are no combinational paths from input to output.
- Tick latency: os_tick is high in the cycle immediately following the edge where the carry occurred.
- First os_tick after clear: the carry occurs on the k-th advancing edge, where k = ceil(2^ACC_W / inc_q). os_tick is visible for the one cycle after that edge.
- Tick spacing is either floor or ceil of 2^ACC_W/inc_q cycles. The long-run average is exact to within 1 LSB of inc.
- The 4-bit table is the only combinational path into inc_nxt.
- Reset asserted mid-bit aborts the current bit with no partial tick. Operation resumes from the reset values on the first edge with rst=0.

## Test plan
- Reset values, default 9600, with CLK_HZ=50e6, OVERSAMPLE=16, ACC_W=24:
  - after rst, inc_out must read 51540;
  - with enable=1, the first os_tick is visible after the 326th edge;
  - 16 os_ticks then give exactly one bit_tick;
  - over 10 bit_ticks the elapsed cycles are 52083 ±1.
- Table sweep:
  - baud_sel=8 gives inc_out=618475;
  - baud_sel=11 gives 4947802;
  - baud_sel=13 gives 51540;
  - over 1e6 cycles the measured os_tick count is within ±1 of inc*1e6/2^24.
- Rate change mid-bit:
  - switch from sel 4 to sel 8 when os_cnt=7;
  - no tick on the switching edge;
  - acc and os_cnt restart from 0;
  - the next bit_tick arrives after 16 os_ticks.
- sync_clr:
  - assert sync_clr on the edge where a carry is due: no os_tick occurs;
  - after sync_clr, mid_tick is 8 os_ticks away (os_cnt=7 on carry) and bit_tick is 16 os_ticks away.
- Custom and enable:
  - use_custom=1, custom_inc=2^23 gives an os_tick every 2 cycles and a bit_tick every 32 cycles;
  - custom_inc=0 gives no ticks for 1000 cycles;
  - with enable=0 for 50 cycles, state holds and the tick phase resumes unchanged afterwards.
- Reset mid-operation: assert rst for 1 cycle at os_cnt=10. On the next cycle all outputs are 0 and inc_out=51540. The first os_tick then occurs 326 edges later.
